tm1638_key_panel: RTL and testbench
===================================

TM1638_KEY_PANEL -- requirements
Module: tm1638_key_panel

Interface
REQ-001 Parameter N_KEYS, default 8, number of panel keys/LEDs; legal range 1..16.
REQ-002 Parameter W_DIGIT, default 8, number of 7-segment digits driven via number/dots; legal range 6..8.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, stable-level cycles required to accept a key change; minimum 2.
REQ-004 clock  input  1  single clock; every register updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 key  input  N_KEYS  raw asynchronous key levels from the TM1638 wrapper, 1 = pressed.
REQ-007 clear  input  1  synchronous, single-cycle, clears the panel state.
REQ-008 led  output  N_KEYS  per-key toggle state, driven to the TM1638 LEDs.
REQ-009 number  output  W_DIGIT*4  hex value for the seven_segment_display instance.
REQ-010 dots  output  W_DIGIT  decimal points for the seven_segment_display instance.
REQ-011 press_valid  output  1  one-cycle pulse per accepted press event.
REQ-012 press_index  output  4  index of the reported key; valid while press_valid = 1.

Function
REQ-013 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each key SHALL have its own debounce counter and debounced state; the counter clears whenever synced level equals debounced state, else increments.
REQ-015 Debounced state SHALL flip when the counter reaches DEBOUNCE_CYCLES-1 with synced level still differing; counter then clears.
REQ-016 A synced pulse or glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change and no event.
REQ-017 A press event SHALL be a 0->1 transition of a debounced state; releases produce no event.
REQ-018 Latency: key held high from edge k SHALL give press_valid = 1 during exactly cycle k+DEBOUNCE_CYCLES+3, for one cycle.
REQ-019 On a press event of key i, led[i] SHALL toggle in the same cycle press_valid asserts.
REQ-020 Simultaneous press events: every pressed key toggles its LED; press_index SHALL report the lowest pressed index; press_valid pulses once.
REQ-021 Press counter, width (W_DIGIT-5)*4, SHALL increment by the popcount of press events in that cycle, wrapping modulo 2^width (default 12 bits: 0xFFF+1 -> 0x000).
REQ-022 last_index (4 bits) and a have_pressed flag SHALL update with each press_valid pulse.
REQ-023 number[15:0] SHALL equal led zero-extended to 16 bits; number[19:16] = last_index; number[W_DIGIT*4-1:20] = press counter.
REQ-024 dots[4] SHALL equal have_pressed; all other dots bits SHALL be 0.
REQ-025 clear = 1 SHALL zero led, counter, last_index, have_pressed next cycle and suppress press_valid and all press effects in that cycle; synchronizers and debounce state are unaffected.
REQ-026 A key already held when clear deasserts SHALL NOT generate a new event until released and re-pressed.
REQ-027 number, dots, led SHALL be registered outputs, with no combinational path from key or clear.

Reset
REQ-028 Reset SHALL zero synchronizers, debounce counters, debounced states, led, counter, last_index, have_pressed, press_valid, press_index, number and dots on the next edge.
REQ-029 Reset SHALL take priority over clear and over any press event in the same cycle.
REQ-030 A key held high through reset deassertion SHALL be accepted as a press DEBOUNCE_CYCLES+3 cycles after reset drops.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count with no event.

Verification (bench uses DEBOUNCE_CYCLES=4, N_KEYS=8, W_DIGIT=8)
REQ-032 key[2] high from edge 10 -> press_valid only at cycle 17, press_index=2, led=0x04, number=0x00120004, dots=0x10.
REQ-033 key[5] pulse of 3 synced cycles -> no press_valid; led, number, dots unchanged.
REQ-034 key[1] and key[6] rise same cycle -> single press_valid, press_index=1, led=0x42, counter +2.
REQ-035 4096 press events on key[0] from reset -> counter wraps to 0x000, led[0]=0.
REQ-036 clear coincident with key[3] press event -> press_valid=0, number=0, led=0, dots=0 next cycle; no later event while key[3] held.
REQ-037 reset pulsed at debounce count 2 of key[7] -> no event; outputs all 0; held key[7] gives event 7 cycles after reset drops.

Source files
------------

// File: rtl/tm1638_key_panel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tm1638_key_panel: debounced TM1638 key panel with per-key LED toggles,
// press counter and status digits for the seven-segment display.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tm1638_key_panel #(
  parameter int N_KEYS          = 8,
  parameter int W_DIGIT         = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_KEYS-1:0]    key,
  input  logic                 clear,
  output logic [N_KEYS-1:0]    led,
  output logic [W_DIGIT*4-1:0] number,
  output logic [W_DIGIT-1:0]   dots,
  output logic                 press_valid,
  output logic [3:0]           press_index
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W  = (W_DIGIT - 5) * 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] deb_q, deb_d;
  logic [N_KEYS-1:0] deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] led_q, led_d;
  logic [PC_W-1:0]   count_q, count_d;
  logic [3:0]        last_q, last_d;
  logic              have_q, have_d;
  logic              pv_q, pv_d;
  logic [3:0]        pidx_q, pidx_d;

  logic [N_KEYS-1:0] rise;
  logic [4:0]        pop;
  logic [3:0]        low_idx;

  always_comb begin
    sync1_d    = key;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // Edge detect on the debounced level: releases and held keys never fire.
    rise    = deb_q & ~deb_prev_q;
    pop     = '0;
    low_idx = '0;
    for (int i = 0; i < N_KEYS; i++) pop = pop + 5'(rise[i]);
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) low_idx = 4'(i);
    end

    led_d   = led_q;
    count_d = count_q;
    last_d  = last_q;
    have_d  = have_q;
    pv_d    = 1'b0;
    pidx_d  = '0;
    if (clear) begin
      led_d   = '0;
      count_d = '0;
      last_d  = '0;
      have_d  = 1'b0;
    end else if (|rise) begin
      led_d   = led_q ^ rise;
      count_d = count_q + PC_W'(pop);
      last_d  = low_idx;
      have_d  = 1'b1;
      pv_d    = 1'b1;
      pidx_d  = low_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      led_q      <= '0;
      count_q    <= '0;
      last_q     <= '0;
      have_q     <= 1'b0;
      pv_q       <= 1'b0;
      pidx_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
      led_q      <= led_d;
      count_q    <= count_d;
      last_q     <= last_d;
      have_q     <= have_d;
      pv_q       <= pv_d;
      pidx_q     <= pidx_d;
    end
  end

  // Display words are pure functions of state flops, so no input reaches them.
  always_comb begin
    number  = {count_q, last_q, 16'(led_q)};
    dots    = '0;
    dots[4] = have_q;
  end

  assign led         = led_q;
  assign press_valid = pv_q;
  assign press_index = pidx_q;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_key_panel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tm1638_key_panel: directed checks of debounce latency, glitch rejection,
// simultaneous presses, counter wrap, clear and reset behaviour.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_tm1638_key_panel;

  localparam int N_KEYS          = 8;
  localparam int W_DIGIT         = 8;
  localparam int DEBOUNCE_CYCLES = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [N_KEYS-1:0]    key   = '0;
  logic                 clear = 1'b0;
  logic [N_KEYS-1:0]    led;
  logic [W_DIGIT*4-1:0] number;
  logic [W_DIGIT-1:0]   dots;
  logic                 press_valid;
  logic [3:0]           press_index;

  int n_checks = 0;
  int n_errors = 0;

  tm1638_key_panel #(
    .N_KEYS          (N_KEYS),
    .W_DIGIT         (W_DIGIT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .clear       (clear),
    .led         (led),
    .number      (number),
    .dots        (dots),
    .press_valid (press_valid),
    .press_index (press_index)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key   = '0;
    clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int pulses;

  initial begin
    // Reset state
    do_reset();
    check_value("rst_led", 32'(led), 32'h0);
    check_value("rst_number", number, 32'h0);
    check_value("rst_dots", 32'(dots), 32'h0);
    check_value("rst_pv", 32'(press_valid), 32'h0);
    check_value("rst_pidx", 32'(press_index), 32'h0);

    // Single press: event exactly DEBOUNCE_CYCLES+3 cycles after key rises
    idle(3);
    key = 8'h04;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check_value($sformatf("lat_pv_t%0d", t), 32'(press_valid), (t == 7) ? 32'h1 : 32'h0);
      if (t == 7) begin
        check_value("lat_pidx", 32'(press_index), 32'h2);
        check_value("lat_led", 32'(led), 32'h04);
        check_value("lat_number", number, 32'h0012_0004);
        check_value("lat_dots", 32'(dots), 32'h10);
      end
    end
    key = '0;
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (press_valid) pulses++;
    end
    check_value("release_no_event", 32'(pulses), 32'h0);

    // Short pulse: 3 synced cycles must be rejected
    key = 8'h20;
    idle(3);
    key = '0;
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (press_valid) pulses++;
    end
    check_value("glitch_no_event", 32'(pulses), 32'h0);
    check_value("glitch_led", 32'(led), 32'h04);
    check_value("glitch_number", number, 32'h0012_0004);
    check_value("glitch_dots", 32'(dots), 32'h10);

    // Simultaneous press of keys 1 and 6
    do_reset();
    idle(2);
    key = 8'h42;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check_value($sformatf("dual_pv_t%0d", t), 32'(press_valid), (t == 7) ? 32'h1 : 32'h0);
      if (t == 7) begin
        check_value("dual_pidx", 32'(press_index), 32'h1);
        check_value("dual_led", 32'(led), 32'h42);
        check_value("dual_number", number, 32'h0021_0042);
      end
    end
    key = '0;
    idle(8);

    // Clear coincident with a press event
    do_reset();
    idle(2);
    key = 8'h04;
    idle(7);
    check_value("pre_clear_pv", 32'(press_valid), 32'h1);
    key = '0;
    idle(8);
    check_value("pre_clear_number", number, 32'h0012_0004);
    key = 8'h08;
    idle(6);
    check_value("clr_pre_pv", 32'(press_valid), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_value("clr_pv", 32'(press_valid), 32'h0);
    check_value("clr_led", 32'(led), 32'h0);
    check_value("clr_number", number, 32'h0);
    check_value("clr_dots", 32'(dots), 32'h0);
    pulses = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (press_valid) pulses++;
    end
    check_value("clr_held_no_event", 32'(pulses), 32'h0);
    key = '0;
    idle(8);
    key = 8'h08;
    idle(7);
    check_value("repress_pv", 32'(press_valid), 32'h1);
    check_value("repress_pidx", 32'(press_index), 32'h3);
    check_value("repress_led", 32'(led), 32'h08);
    check_value("repress_number", number, 32'h0013_0008);
    check_value("repress_dots", 32'(dots), 32'h10);
    key = '0;
    idle(8);

    // Reset mid-debounce discards the partial count
    do_reset();
    idle(2);
    key = 8'h80;
    idle(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_value("middeb_led", 32'(led), 32'h0);
    check_value("middeb_number", number, 32'h0);
    check_value("middeb_dots", 32'(dots), 32'h0);
    check_value("middeb_pv", 32'(press_valid), 32'h0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      check_value($sformatf("postrst_pv_t%0d", t), 32'(press_valid), (t == 7) ? 32'h1 : 32'h0);
      if (t == 7) begin
        check_value("postrst_pidx", 32'(press_index), 32'h7);
        check_value("postrst_led", 32'(led), 32'h80);
        check_value("postrst_number", number, 32'h0017_0080);
      end
    end
    key = '0;
    idle(8);

    // 4096 presses on key 0: counter wraps, LED ends off
    do_reset();
    idle(2);
    pulses = 0;
    for (int n = 0; n < 4096; n++) begin
      key = 8'h01;
      for (int t = 0; t < 5; t++) begin
        tick();
        if (press_valid) pulses++;
      end
      key = '0;
      for (int t = 0; t < 5; t++) begin
        tick();
        if (press_valid) pulses++;
      end
      if (n == 4094) begin
        check_value("wrap_pre_count", 32'(pulses), 32'd4095);
        check_value("wrap_pre_counter", 32'(number[31:20]), 32'hFFF);
        check_value("wrap_pre_led", 32'(led), 32'h01);
      end
    end
    check_value("wrap_count", 32'(pulses), 32'd4096);
    check_value("wrap_counter", 32'(number[31:20]), 32'h000);
    check_value("wrap_led", 32'(led), 32'h00);
    check_value("wrap_number", number, 32'h0);
    check_value("wrap_dots", 32'(dots), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
